// File: rtl/i2c_fifo_status.sv
// Paired TX/RX byte FIFOs for the I2C controller, with occupancy counts and a status byte.
// Each FIFO is first-word-fall-through and keeps sticky overflow/underflow flags.

module i2c_fifo_chan #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          wr_en,
    input  logic [7:0]    wdata,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          err_clr,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;
    logic          ovf_evt;
    logic          udf_evt;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A pop frees the slot a same-cycle push needs, so a full FIFO accepts push+pop.
    assign push_ok = wr_en & ~flush & (~full | rd_en);
    assign pop_ok  = rd_en & ~flush & ~empty;
    assign ovf_evt = wr_en & ~flush & full & ~rd_en;
    assign udf_evt = rd_en & ~flush & empty;

    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A set event in the same cycle as err_clr wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (udf_evt) begin
                udf <= 1'b1;
            end else if (err_clr) begin
                udf <= 1'b0;
            end
        end
    end

    assign rdata = empty ? 8'h00 : mem[rd_ptr];
    assign count = cnt;
endmodule

module i2c_fifo_status #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          tx_wr_en,
    input  logic [7:0]    tx_wdata,
    input  logic          tx_rd_en,
    output logic [7:0]    tx_rdata,
    input  logic          rx_wr_en,
    input  logic [7:0]    rx_wdata,
    input  logic          rx_rd_en,
    output logic [7:0]    rx_rdata,
    input  logic          tx_flush,
    input  logic          rx_flush,
    input  logic          err_clr,
    output logic [7:0]    status_reg,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count
);
    logic tx_full, tx_empty, tx_ovf, tx_udf;
    logic rx_full, rx_empty, rx_ovf, rx_udf;

    i2c_fifo_chan #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .wr_en   (tx_wr_en),
        .wdata   (tx_wdata),
        .rd_en   (tx_rd_en),
        .flush   (tx_flush),
        .err_clr (err_clr),
        .rdata   (tx_rdata),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty),
        .ovf     (tx_ovf),
        .udf     (tx_udf)
    );

    i2c_fifo_chan #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .wr_en   (rx_wr_en),
        .wdata   (rx_wdata),
        .rd_en   (rx_rd_en),
        .flush   (rx_flush),
        .err_clr (err_clr),
        .rdata   (rx_rdata),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty),
        .ovf     (rx_ovf),
        .udf     (rx_udf)
    );

    assign status_reg = {tx_full, tx_empty, rx_full, rx_empty,
                         tx_ovf, rx_ovf, tx_udf, rx_udf};
endmodule

// File: tb/tb_i2c_fifo_status.sv
// Bench for i2c_fifo_status: directed scenarios plus random traffic against a
// queue-based reference model of both FIFOs and their sticky flags.

module tb_i2c_fifo_status;
    localparam int D = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       tx_wr_en = 0, tx_rd_en = 0, rx_wr_en = 0, rx_rd_en = 0;
    logic [7:0] tx_wdata = 0, rx_wdata = 0;
    logic       tx_flush = 0, rx_flush = 0, err_clr = 0;
    logic [7:0] tx_rdata, rx_rdata, status_reg;
    logic [3:0] tx_count, rx_count;

    i2c_fifo_status #(.DEPTH(D), .AW(3)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .tx_wr_en   (tx_wr_en),
        .tx_wdata   (tx_wdata),
        .tx_rd_en   (tx_rd_en),
        .tx_rdata   (tx_rdata),
        .rx_wr_en   (rx_wr_en),
        .rx_wdata   (rx_wdata),
        .rx_rd_en   (rx_rd_en),
        .rx_rdata   (rx_rdata),
        .tx_flush   (tx_flush),
        .rx_flush   (rx_flush),
        .err_clr    (err_clr),
        .status_reg (status_reg),
        .tx_count   (tx_count),
        .rx_count   (rx_count)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_tovf = 0, m_rovf = 0, m_tudf = 0, m_rudf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {txq.size() == D, txq.size() == 0, rxq.size() == D, rxq.size() == 0,
                m_tovf, m_rovf, m_tudf, m_rudf};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".status"},   32'(status_reg), 32'(exp_status()));
        check({tag, ".tx_count"}, 32'(tx_count),   32'(txq.size()));
        check({tag, ".rx_count"}, 32'(rx_count),   32'(rxq.size()));
        check({tag, ".tx_rdata"}, 32'(tx_rdata),   32'(txq.size() > 0 ? txq[0] : 8'h00));
        check({tag, ".rx_rdata"}, 32'(rx_rdata),   32'(rxq.size() > 0 ? rxq[0] : 8'h00));
    endtask

    // One FIFO's behaviour for one clock, from the pre-edge occupancy.
    task automatic model_fifo(inout logic [7:0] q[$], input logic wr, input logic [7:0] d,
                              input logic rd, input logic fl, inout logic ovf, inout logic udf);
        int  n;
        logic ovf_ev, udf_ev;
        n = q.size();
        ovf_ev = 0;
        udf_ev = 0;
        if (fl) begin
            q.delete();
        end else begin
            ovf_ev = wr && n == D && !rd;
            udf_ev = rd && n == 0;
            if (rd && n > 0) void'(q.pop_front());
            if (wr && (n < D || rd)) q.push_back(d);
        end
        if (ovf_ev) ovf = 1; else if (err_clr) ovf = 0;
        if (udf_ev) udf = 1; else if (err_clr) udf = 0;
    endtask

    task automatic step(input string tag, input logic twr, input logic [7:0] td, input logic trd,
                        input logic rwr, input logic [7:0] rd_, input logic rrd,
                        input logic tfl, input logic rfl, input logic ecl);
        tx_wr_en = twr; tx_wdata = td; tx_rd_en = trd;
        rx_wr_en = rwr; rx_wdata = rd_; rx_rd_en = rrd;
        tx_flush = tfl; rx_flush = rfl; err_clr = ecl;
        @(posedge PCLK);
        model_fifo(txq, twr, td, trd, tfl, m_tovf, m_tudf);
        model_fifo(rxq, rwr, rd_, rrd, rfl, m_rovf, m_rudf);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge PCLK);
        PRESETn = 0;
        txq.delete(); rxq.delete();
        m_tovf = 0; m_rovf = 0; m_tudf = 0; m_rudf = 0;
        #1;
        check({tag, ".status_in_reset"}, 32'(status_reg), 32'h50);
        check_all(tag);
        @(negedge PCLK);
        PRESETn = 1;
    endtask

    initial begin
        #2;
        check("reset.status_asserted", 32'(status_reg), 32'h50);
        check_all("reset");
        #20;
        @(negedge PCLK);
        PRESETn = 1;
        idle("idle");
        check("idle.status", 32'(status_reg), 32'h50);

        // Fill TX, overflow, drain.
        for (int i = 0; i < 8; i++) step("tx_fill", 1, 8'hA1 + 8'(i), 0, 0, 0, 0, 0, 0, 0);
        check("tx_fill.count8", 32'(tx_count), 32'd8);
        step("tx_ovf", 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
        check("tx_ovf.bit3", 32'(status_reg[3]), 32'd1);
        for (int i = 0; i < 8; i++) step("tx_drain", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("tx_drain.empty", 32'(status_reg[6]), 32'd1);

        // Full FIFO with simultaneous push and pop.
        step("eclr", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("tx_refill", 1, 8'hA1 + 8'(i), 0, 0, 0, 0, 0, 0, 0);
        step("tx_full_pp", 1, 8'h55, 1, 0, 0, 0, 0, 0, 0);
        check("tx_full_pp.count", 32'(tx_count), 32'd8);
        check("tx_full_pp.no_ovf", 32'(status_reg[3]), 32'd0);
        for (int i = 0; i < 8; i++) step("tx_drain2", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Empty RX with simultaneous pop and push.
        step("rx_empty_pp", 0, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
        check("rx_empty_pp.rdata", 32'(rx_rdata), 32'h3C);
        check("rx_empty_pp.udf", 32'(status_reg[0]), 32'd1);
        step("rx_eclr", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rx_eclr.udf", 32'(status_reg[0]), 32'd0);
        step("rx_pop", 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Wrap with low occupancy.
        step("wrap", 0, 0, 0, 1, 8'h10, 0, 0, 0, 0);
        step("wrap", 0, 0, 0, 1, 8'h11, 0, 0, 0, 0);
        for (int i = 2; i < 20; i++) step("wrap", 0, 0, 0, 1, 8'h10 + 8'(i), 1, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("wrap.sticky", 32'(status_reg[3:0]), 32'd0);

        // Flush wins over push; reset mid-stream.
        for (int i = 0; i < 5; i++) step("flush_prep", 1, 8'h70 + 8'(i), 0, 1, 8'h80 + 8'(i), 0, 0, 0, 0);
        step("tx_flush", 1, 8'hEE, 0, 0, 0, 0, 1, 0, 0);
        check("tx_flush.count", 32'(tx_count), 32'd0);
        check("tx_flush.rx_kept", 32'(rx_count), 32'd5);
        apply_reset("mid_reset");
        step("post_reset_pop", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("post_reset_pop.udf", 32'(status_reg[1]), 32'd1);

        // Random traffic; bias phases push occupancy toward full and empty.
        for (int ph = 0; ph < 8; ph++) begin
            int wp, rp;
            wp = (ph % 2 == 0) ? 75 : 25;
            rp = 100 - wp;
            for (int c = 0; c < 150; c++) begin
                step("rand",
                     $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                     $urandom_range(0, 99) < rp, 8'($urandom), $urandom_range(0, 99) < wp,
                     $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 5);
            end
            if (ph == 4) apply_reset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
